saturn_regfile_nbl: RTL and testbench



---
 rtl/saturn_regfile_nbl_pkg.sv | 34 +++
 rtl/saturn_regfile_nbl_bank.sv | 37 +++
 rtl/saturn_regfile_nbl.sv | 173 +++++++++++++++++
 tb/tb_saturn_regfile_nbl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/saturn_regfile_nbl_pkg.sv
// Shared ALU register codes and register-file helpers for the Saturn nibble register file.
// Used by saturn_regfile_nbl (optional same-cycle read bypass: SATURN_REGFILE_BYPASS_EN).
package saturn_regfile_nbl_pkg;

  typedef enum logic [4:0] {
    ALU_REG_A  = 5'd0,
    ALU_REG_B  = 5'd1,
    ALU_REG_C  = 5'd2,
    ALU_REG_D  = 5'd3,
    ALU_REG_R0 = 5'd4,
    ALU_REG_R1 = 5'd5,
    ALU_REG_R2 = 5'd6,
    ALU_REG_R3 = 5'd7,
    ALU_REG_R4 = 5'd8,
    ALU_REG_D0 = 5'd9,
    ALU_REG_D1 = 5'd10
  } alu_reg_e;

  localparam int NUM_REGS = 11;

  typedef enum logic {
    RF_INIT  = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  function automatic logic reg_code_defined(input logic [4:0] code);
    return (code <= ALU_REG_D1);
  endfunction

  function automatic logic reg_is_narrow(input logic [4:0] code);
    return (code == ALU_REG_D0) || (code == ALU_REG_D1);
  endfunction

endpackage

// File: rtl/saturn_regfile_nbl_bank.sv
// One register's nibble array: a clear port plus N_WR write ports, lowest port index wins.
module saturn_regfile_bank
  import saturn_regfile_nbl_pkg::*;
#(
  parameter int NIB   = 16,
  parameter int N_WR  = 2,
  parameter int PTR_W = 4
) (
  input  logic                  i_clk,
  input  logic                  i_clr,
  input  logic [PTR_W-1:0]      i_clr_ptr,
  input  logic [N_WR-1:0]       i_wr_en,
  input  logic [N_WR*PTR_W-1:0] i_wr_ptr,
  input  logic [N_WR*4-1:0]     i_wr_nbl,
  output logic [NIB*4-1:0]      o_q
);

  logic [NIB-1:0][3:0] mem_r;

  // Nibble storage: clear has precedence; ports scanned high-to-low so port 0 lands last
  always_ff @(posedge i_clk) begin
    for (int n = 0; n < NIB; n++) begin
      if (i_clr && (i_clr_ptr == PTR_W'(n))) begin
        mem_r[n] <= 4'h0;
      end else begin
        for (int p = N_WR - 1; p >= 0; p--) begin
          if (i_wr_en[p] && (i_wr_ptr[p*PTR_W +: PTR_W] == PTR_W'(n))) begin
            mem_r[n] <= i_wr_nbl[p*4 +: 4];
          end
        end
      end
    end
  end

  assign o_q = mem_r;

endmodule

// File: rtl/saturn_regfile_nbl.sv
// Saturn nibble-addressed register file with power-up clear sequencer.
// Define SATURN_REGFILE_BYPASS_EN to forward same-cycle committed writes to matching reads.
module saturn_regfile_nbl
  import saturn_regfile_nbl_pkg::*;
#(
  parameter int N_NIBBLES      = 16,
  parameter int NARROW_NIBBLES = 5,
  parameter int N_RD           = 2,
  parameter int N_WR           = 2,
  parameter int PTR_W          = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_stalled,
  input  logic                  i_ins_decoded,
  input  logic                  i_phase_3,
  input  logic [N_RD*5-1:0]     i_rd_sel,
  input  logic [N_RD*PTR_W-1:0] i_rd_ptr,
  output logic [N_RD*4-1:0]     o_rd_nbl,
  output logic [N_RD-1:0]       o_rd_valid,
  input  logic [N_WR-1:0]       i_wr_en,
  input  logic [N_WR*5-1:0]     i_wr_sel,
  input  logic [N_WR*PTR_W-1:0] i_wr_ptr,
  input  logic [N_WR*4-1:0]     i_wr_nbl,
  output logic                  o_ready,
  output logic [N_WR-1:0]       o_wr_drop
);

  localparam logic [PTR_W:0]   FULL_LIM_C   = (PTR_W+1)'(N_NIBBLES);
  localparam logic [PTR_W:0]   NARROW_LIM_C = (PTR_W+1)'(NARROW_NIBBLES);
  localparam logic [PTR_W-1:0] LAST_PTR_C   = PTR_W'(N_NIBBLES - 1);

  function automatic logic loc_valid(input logic [4:0] code, input logic [PTR_W-1:0] ptr);
    if (!reg_code_defined(code)) begin
      return 1'b0;
    end else if (reg_is_narrow(code)) begin
      return ({1'b0, ptr} < NARROW_LIM_C);
    end else begin
      return ({1'b0, ptr} < FULL_LIM_C);
    end
  endfunction

  rf_state_e            state_r, state_s;
  logic [PTR_W-1:0]     clr_cnt_r, clr_cnt_s;
  logic                 ready_s, commit_s, clr_en_s;
  logic [N_WR-1:0]      wr_commit_s, drop_s, wr_drop_r;
  logic [N_RD*4-1:0]    rd_nbl_s;
  logic [N_RD-1:0]      rd_valid_s;
  logic [N_NIBBLES*4-1:0] reg_q_s [16];

  // Init sequencer state and clear counter
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_r   <= RF_INIT;
      clr_cnt_r <= {PTR_W{1'b0}};
    end else begin
      state_r   <= state_s;
      clr_cnt_r <= clr_cnt_s;
    end
  end

  // Next-state: walk the clear pointer across every nibble, then hold READY
  always_comb begin
    state_s   = state_r;
    clr_cnt_s = clr_cnt_r;
    case (state_r)
      RF_INIT: begin
        if (clr_cnt_r == LAST_PTR_C) begin
          state_s   = RF_READY;
          clr_cnt_s = {PTR_W{1'b0}};
        end else begin
          clr_cnt_s = clr_cnt_r + PTR_W'(1);
        end
      end
      RF_READY: begin
        state_s = RF_READY;
      end
      default: begin
        state_s   = RF_INIT;
        clr_cnt_s = {PTR_W{1'b0}};
      end
    endcase
  end

  assign ready_s  = (state_r == RF_READY);
  assign clr_en_s = (state_r == RF_INIT);
  assign commit_s = ready_s & ~i_stalled & i_ins_decoded & i_phase_3;
  assign o_ready  = ready_s;

  // Write qualification: bad location or not-ready requests are dropped, commit-less ones just idle
  always_comb begin
    wr_commit_s = {N_WR{1'b0}};
    drop_s      = {N_WR{1'b0}};
    for (int p = 0; p < N_WR; p++) begin
      wr_commit_s[p] = i_wr_en[p] & commit_s &
                       loc_valid(i_wr_sel[p*5 +: 5], i_wr_ptr[p*PTR_W +: PTR_W]);
      drop_s[p]      = i_wr_en[p] &
                       (~ready_s | ~loc_valid(i_wr_sel[p*5 +: 5], i_wr_ptr[p*PTR_W +: PTR_W]));
    end
  end

  // Registered drop pulse
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      wr_drop_r <= {N_WR{1'b0}};
    end else begin
      wr_drop_r <= drop_s;
    end
  end

  assign o_wr_drop = wr_drop_r;

  for (genvar r = 0; r < 16; r++) begin : g_reg
    if (r < NUM_REGS) begin : g_bank
      localparam int NB = ((r == int'(ALU_REG_D0)) || (r == int'(ALU_REG_D1))) ?
                          NARROW_NIBBLES : N_NIBBLES;
      logic [N_WR-1:0] wr_en_s;
      logic [NB*4-1:0] q_s;

      // Per-bank write enables from the shared commit decode
      always_comb begin
        wr_en_s = {N_WR{1'b0}};
        for (int p = 0; p < N_WR; p++) begin
          wr_en_s[p] = wr_commit_s[p] & (i_wr_sel[p*5 +: 5] == 5'(r));
        end
      end

      saturn_regfile_bank #(
        .NIB   (NB),
        .N_WR  (N_WR),
        .PTR_W (PTR_W)
      ) u_bank (
        .i_clk     (i_clk),
        .i_clr     (clr_en_s),
        .i_clr_ptr (clr_cnt_r),
        .i_wr_en   (wr_en_s),
        .i_wr_ptr  (i_wr_ptr),
        .i_wr_nbl  (i_wr_nbl),
        .o_q       (q_s)
      );

      assign reg_q_s[r] = (N_NIBBLES*4)'(q_s);
    end else begin : g_pad
      assign reg_q_s[r] = {(N_NIBBLES*4){1'b0}};
    end
  end

  // Zero-latency read mux, optionally forwarding the winning same-cycle write
  always_comb begin
    rd_nbl_s   = {(N_RD*4){1'b0}};
    rd_valid_s = {N_RD{1'b0}};
    for (int q = 0; q < N_RD; q++) begin
      rd_valid_s[q] = ready_s & loc_valid(i_rd_sel[q*5 +: 5], i_rd_ptr[q*PTR_W +: PTR_W]);
      if (rd_valid_s[q]) begin
        rd_nbl_s[q*4 +: 4] = reg_q_s[i_rd_sel[q*5 +: 4]][i_rd_ptr[q*PTR_W +: PTR_W]*4 +: 4];
`ifdef SATURN_REGFILE_BYPASS_EN
        for (int p = N_WR - 1; p >= 0; p--) begin
          rd_nbl_s[q*4 +: 4] = (wr_commit_s[p] &&
                                (i_wr_sel[p*5 +: 5] == i_rd_sel[q*5 +: 5]) &&
                                (i_wr_ptr[p*PTR_W +: PTR_W] == i_rd_ptr[q*PTR_W +: PTR_W])) ?
                               i_wr_nbl[p*4 +: 4] : rd_nbl_s[q*4 +: 4];
        end
`endif
      end else begin
        rd_nbl_s[q*4 +: 4] = 4'h0;
      end
    end
  end

  assign o_rd_nbl   = rd_nbl_s;
  assign o_rd_valid = rd_valid_s;

endmodule

// File: tb/tb_saturn_regfile_nbl.sv
// Directed self-checking bench for saturn_regfile_nbl (honours SATURN_REGFILE_BYPASS_EN).
module tb_saturn_regfile_nbl;
  import saturn_regfile_nbl_pkg::*;

  localparam int N_RD = 2;
  localparam int N_WR = 2;
  localparam int PTR_W = 4;
`ifdef SATURN_REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                  i_clk = 1'b0;
  logic                  i_reset, i_stalled, i_ins_decoded, i_phase_3;
  logic [N_RD*5-1:0]     i_rd_sel;
  logic [N_RD*PTR_W-1:0] i_rd_ptr;
  logic [N_RD*4-1:0]     o_rd_nbl;
  logic [N_RD-1:0]       o_rd_valid;
  logic [N_WR-1:0]       i_wr_en;
  logic [N_WR*5-1:0]     i_wr_sel;
  logic [N_WR*PTR_W-1:0] i_wr_ptr;
  logic [N_WR*4-1:0]     i_wr_nbl;
  logic                  o_ready;
  logic [N_WR-1:0]       o_wr_drop;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  saturn_regfile_nbl dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_stalled(i_stalled),
    .i_ins_decoded(i_ins_decoded), .i_phase_3(i_phase_3),
    .i_rd_sel(i_rd_sel), .i_rd_ptr(i_rd_ptr), .o_rd_nbl(o_rd_nbl), .o_rd_valid(o_rd_valid),
    .i_wr_en(i_wr_en), .i_wr_sel(i_wr_sel), .i_wr_ptr(i_wr_ptr), .i_wr_nbl(i_wr_nbl),
    .o_ready(o_ready), .o_wr_drop(o_wr_drop)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_rd(input int q, input logic [4:0] sel, input logic [3:0] ptr);
    i_rd_sel[q*5 +: 5]         = sel;
    i_rd_ptr[q*PTR_W +: PTR_W] = ptr;
  endtask

  task automatic set_wr(input int p, input logic [4:0] sel, input logic [3:0] ptr, input logic [3:0] nbl);
    i_wr_en[p]                 = 1'b1;
    i_wr_sel[p*5 +: 5]         = sel;
    i_wr_ptr[p*PTR_W +: PTR_W] = ptr;
    i_wr_nbl[p*4 +: 4]         = nbl;
  endtask

  task automatic set_commit(input logic c);
    i_stalled     = 1'b0;
    i_ins_decoded = c;
    i_phase_3     = c;
  endtask

  task automatic test_reset();
    int cyc;
    int lim;
    i_reset = 1'b0;
    i_wr_en = 2'b00; i_wr_sel = '0; i_wr_ptr = '0; i_wr_nbl = '0;
    i_rd_sel = '0; i_rd_ptr = '0;
    set_commit(1'b0);
    tick(); tick();
    checks++;
    if (o_ready !== 1'b0 || o_wr_drop !== 2'b00 || o_rd_valid !== 2'b00) begin
      failures++;
      $display("FAIL reset_state ready=%b drop=%b valid=%b required 0/00/00", o_ready, o_wr_drop, o_rd_valid);
    end
    i_reset = 1'b1;
    cyc = 0;
    while (o_ready !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 16) begin
      failures++;
      $display("FAIL init_length cycles=%0d required 16", cyc);
    end
    for (int r = 0; r < 11; r++) begin
      lim = (r >= 9) ? 5 : 16;
      for (int n = 0; n < lim; n++) begin
        set_rd(0, 5'(r), 4'(n));
        set_rd(1, 5'(r), 4'(lim - 1 - n));
        #1;
        checks++;
        if (o_rd_nbl !== 8'h00 || o_rd_valid !== 2'b11) begin
          failures++;
          $display("FAIL init_clear reg=%0d nib=%0d nbl=%h valid=%b required 00/11", r, n, o_rd_nbl, o_rd_valid);
        end
      end
    end
    // out-of-range narrow pointer and undefined code
    set_rd(0, ALU_REG_D1, 4'd5);
    set_rd(1, 5'd11, 4'd0);
    #1;
    checks++;
    if (o_rd_nbl !== 8'h00 || o_rd_valid !== 2'b00) begin
      failures++;
      $display("FAIL invalid_read nbl=%h valid=%b required 00/00", o_rd_nbl, o_rd_valid);
    end
  endtask

  task automatic test_write_read();
    set_wr(0, ALU_REG_A, 4'd3, 4'hA);
    set_commit(1'b1);
    tick();
    i_wr_en = 2'b00;
    set_commit(1'b0);
    set_rd(0, ALU_REG_A, 4'd3);
    set_rd(1, ALU_REG_A, 4'd2);
    #1;
    checks++;
    if (o_rd_nbl !== 8'h0A || o_rd_valid !== 2'b11 || o_wr_drop !== 2'b00) begin
      failures++;
      $display("FAIL write_read nbl=%h valid=%b drop=%b required 0a/11/00", o_rd_nbl, o_rd_valid, o_wr_drop);
    end
  endtask

  task automatic test_no_commit();
    set_wr(0, ALU_REG_A, 4'd4, 4'h6);
    set_commit(1'b1);
    i_stalled = 1'b1;
    tick();
    checks++;
    if (o_wr_drop !== 2'b00) begin
      failures++;
      $display("FAIL stalled_no_drop drop=%b required 00", o_wr_drop);
    end
    i_wr_en = 2'b00;
    set_wr(1, ALU_REG_A, 4'd5, 4'h9);
    i_stalled = 1'b0;
    i_phase_3 = 1'b0;
    tick();
    i_wr_en = 2'b00;
    set_commit(1'b0);
    set_rd(0, ALU_REG_A, 4'd4);
    set_rd(1, ALU_REG_A, 4'd5);
    #1;
    checks++;
    if (o_rd_nbl !== 8'h00 || o_rd_valid !== 2'b11 || o_wr_drop !== 2'b00) begin
      failures++;
      $display("FAIL no_commit nbl=%h valid=%b drop=%b required 00/11/00", o_rd_nbl, o_rd_valid, o_wr_drop);
    end
  endtask

  task automatic test_collision();
    set_wr(0, ALU_REG_C, 4'd7, 4'h5);
    set_wr(1, ALU_REG_C, 4'd7, 4'h9);
    set_commit(1'b1);
    tick();
    i_wr_en = 2'b00;
    set_commit(1'b0);
    set_rd(0, ALU_REG_C, 4'd7);
    set_rd(1, ALU_REG_C, 4'd6);
    #1;
    checks++;
    if (o_rd_nbl !== 8'h05 || o_rd_valid !== 2'b11 || o_wr_drop !== 2'b00) begin
      failures++;
      $display("FAIL collision nbl=%h valid=%b drop=%b required 05/11/00", o_rd_nbl, o_rd_valid, o_wr_drop);
    end
  endtask

  task automatic test_multi();
    set_wr(0, ALU_REG_D, 4'd1, 4'h1);
    set_wr(1, ALU_REG_R2, 4'd15, 4'hE);
    set_commit(1'b1);
    tick();
    i_wr_en = 2'b00;
    set_commit(1'b0);
    set_rd(0, ALU_REG_D, 4'd1);
    set_rd(1, ALU_REG_R2, 4'd15);
    #1;
    checks++;
    if (o_rd_nbl !== 8'hE1 || o_rd_valid !== 2'b11) begin
      failures++;
      $display("FAIL multi_write nbl=%h valid=%b required e1/11", o_rd_nbl, o_rd_valid);
    end
  endtask

  task automatic test_drop();
    set_wr(0, ALU_REG_D0, 4'd6, 4'hF);
    set_wr(1, ALU_REG_D0, 4'd4, 4'h8);
    set_commit(1'b1);
    tick();
    i_wr_en = 2'b00;
    set_commit(1'b0);
    set_rd(0, ALU_REG_D0, 4'd6);
    set_rd(1, ALU_REG_D0, 4'd4);
    #1;
    checks++;
    if (o_wr_drop !== 2'b01 || o_rd_nbl !== 8'h80 || o_rd_valid !== 2'b10) begin
      failures++;
      $display("FAIL narrow_drop drop=%b nbl=%h valid=%b required 01/80/10", o_wr_drop, o_rd_nbl, o_rd_valid);
    end
    tick();
    checks++;
    if (o_wr_drop !== 2'b00) begin
      failures++;
      $display("FAIL drop_pulse_width drop=%b required 00", o_wr_drop);
    end
    set_wr(1, 5'd31, 4'd0, 4'h2);
    tick();
    i_wr_en = 2'b00;
    checks++;
    if (o_wr_drop !== 2'b10) begin
      failures++;
      $display("FAIL undef_code_drop drop=%b required 10", o_wr_drop);
    end
    tick();
    checks++;
    if (o_wr_drop !== 2'b00) begin
      failures++;
      $display("FAIL undef_drop_clear drop=%b required 00", o_wr_drop);
    end
  endtask

  task automatic test_bypass();
    logic [3:0] exp0;
    set_rd(0, ALU_REG_B, 4'd2);
    set_rd(1, ALU_REG_B, 4'd3);
    set_wr(0, ALU_REG_B, 4'd2, 4'h3);
    set_commit(1'b1);
    #1;
    exp0 = BYPASS ? 4'h3 : 4'h0;
    checks++;
    if (o_rd_nbl !== {4'h0, exp0} || o_rd_valid !== 2'b11) begin
      failures++;
      $display("FAIL same_cycle_read nbl=%h valid=%b required %h/11", o_rd_nbl, o_rd_valid, {4'h0, exp0});
    end
    tick();
    i_wr_en = 2'b00;
    #1;
    checks++;
    if (o_rd_nbl !== 8'h03) begin
      failures++;
      $display("FAIL after_bypass_write nbl=%h required 03", o_rd_nbl);
    end
    set_wr(0, ALU_REG_B, 4'd2, 4'h4);
    set_wr(1, ALU_REG_B, 4'd2, 4'hC);
    #1;
    exp0 = BYPASS ? 4'h4 : 4'h3;
    checks++;
    if (o_rd_nbl[3:0] !== exp0) begin
      failures++;
      $display("FAIL bypass_priority nbl=%h required %h", o_rd_nbl[3:0], exp0);
    end
    tick();
    i_wr_en = 2'b00;
    set_commit(1'b0);
    #1;
    checks++;
    if (o_rd_nbl[3:0] !== 4'h4) begin
      failures++;
      $display("FAIL priority_store nbl=%h required 4", o_rd_nbl[3:0]);
    end
  endtask

  task automatic test_reset_ready();
    int cyc;
    set_wr(0, ALU_REG_R4, 4'd0, 4'h7);
    set_commit(1'b1);
    tick();
    i_wr_en = 2'b00;
    set_commit(1'b0);
    set_rd(0, ALU_REG_R4, 4'd0);
    #1;
    checks++;
    if (o_rd_nbl[3:0] !== 4'h7 || o_rd_valid[0] !== 1'b1) begin
      failures++;
      $display("FAIL r4_write nbl=%h valid=%b required 7/1", o_rd_nbl[3:0], o_rd_valid[0]);
    end
    i_reset = 1'b0;
    tick();
    checks++;
    if (o_ready !== 1'b0 || o_rd_valid !== 2'b00) begin
      failures++;
      $display("FAIL ready_drop ready=%b valid=%b required 0/00", o_ready, o_rd_valid);
    end
    i_reset = 1'b1;
    set_wr(0, ALU_REG_A, 4'd9, 4'h1);
    set_commit(1'b1);
    tick();
    i_wr_en = 2'b00;
    set_commit(1'b0);
    checks++;
    if (o_wr_drop !== 2'b01 || o_ready !== 1'b0) begin
      failures++;
      $display("FAIL init_write_drop drop=%b ready=%b required 01/0", o_wr_drop, o_ready);
    end
    cyc = 1;
    while (o_ready !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 16) begin
      failures++;
      $display("FAIL reinit_length cycles=%0d required 16", cyc);
    end
    set_rd(0, ALU_REG_R4, 4'd0);
    set_rd(1, ALU_REG_A, 4'd3);
    #1;
    checks++;
    if (o_rd_nbl !== 8'h00 || o_rd_valid !== 2'b11) begin
      failures++;
      $display("FAIL reinit_clear nbl=%h valid=%b required 00/11", o_rd_nbl, o_rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_no_commit();
    test_collision();
    test_multi();
    test_drop();
    test_bypass();
    test_reset_ready();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
